// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding,
// config-length width helper and the power-on configuration.
package seq_det_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HUNT = 1'b1
    } state_t;

    localparam int PAT_W_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;
    localparam logic [3:0] PAT_DEFAULT_4 = 4'b1011;

    // Width needed to hold a length in 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count holds once it reaches all-ones.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with registered match pulse
// and saturating match counter. Define SEQDET_GAP_EN to add gap_len/gap_valid.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int              PAT_W       = PAT_W_DEFAULT,
    parameter int              CNT_W       = CNT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_4)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_bit,
    input  logic                      cfg_load,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic [len_w(PAT_W)-1:0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      clr_count,
    output logic                      match,
    output logic [CNT_W-1:0]          match_count,
`ifdef SEQDET_GAP_EN
    output logic [CNT_W-1:0]          gap_len,
    output logic                      gap_valid,
`endif
    output logic                      cfg_err
);

    localparam int LEN_W = len_w(PAT_W);

    state_t             state;
    logic [PAT_W-1:0]   hist;
    logic [LEN_W-1:0]   fill_cnt;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic               len_legal;
    logic               cfg_ok;
    logic               accept;
    logic [PAT_W-1:0]   hist_nxt;
    logic [LEN_W-1:0]   fill_inc;
    logic               full;
    logic               hit;
    logic               match_nxt;

    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // A legal load claims the cycle, so a coincident input bit is dropped.
    always_comb begin
        len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
        cfg_ok    = cfg_load && len_legal;
        accept    = in_valid && !cfg_ok;
        hist_nxt  = {hist[PAT_W-2:0], in_bit};
        fill_inc  = fill_cnt + 1'b1;
        full      = (state == S_HUNT) || (fill_inc >= len_q);
        hit       = ((hist_nxt ^ pat_q) & len_mask(len_q)) == '0;
        match_nxt = accept && full && hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FILL;
            hist     <= '0;
            fill_cnt <= '0;
            pat_q    <= PAT_DEFAULT;
            len_q    <= LEN_W'(PAT_W);
            ovl_q    <= 1'b1;
            match    <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            match   <= match_nxt;
            cfg_err <= cfg_load && !len_legal;
            if (cfg_ok) begin
                pat_q    <= cfg_pattern;
                len_q    <= cfg_len;
                ovl_q    <= cfg_overlap;
                hist     <= '0;
                fill_cnt <= '0;
                state    <= S_FILL;
            end else if (accept) begin
                hist <= hist_nxt;
                if (!full) begin
                    fill_cnt <= fill_inc;
                end else if (hit && !ovl_q) begin
                    // Non-overlapping: the next match must be built from fresh bits.
                    fill_cnt <= '0;
                    state    <= S_FILL;
                end else begin
                    fill_cnt <= len_q;
                    state    <= S_HUNT;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clr_count),
        .count (match_count)
    );

`ifdef SEQDET_GAP_EN
    logic [CNT_W-1:0] since_cnt;
    logic             seen_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Bits accepted since the final bit of the previous match.
    sat_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clr   (match_nxt || cfg_ok),
        .count (since_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_len    <= '0;
            gap_valid  <= 1'b0;
            seen_match <= 1'b0;
        end else if (cfg_ok) begin
            gap_len    <= '0;
            gap_valid  <= 1'b0;
            seen_match <= 1'b0;
        end else if (match_nxt) begin
            seen_match <= 1'b1;
            if (seen_match) begin
                gap_len   <= sat_inc(since_cnt);
                gap_valid <= 1'b1;
            end
        end
    end
`endif

endmodule
